bcd_display_scanner: RTL and testbench

Time-multiplexed two-digit seven-segment driver that consumes the 8-bit packed BCD word produced by the binary-to-BCD converter. It sits directly downstream of that converter and accepts a new value through a valid/ready handshake into a one-entry pending buffer. The buffered value is swapped into the display register only at a frame boundary, so a digit pair is never shown torn. The block then scans the ones and tens digits onto shared segment lines.

---
 rtl/bcd_disp_pkg.sv | 28 ++
 rtl/bcd_seg_decoder.sv | 28 ++
 rtl/bcd_display_scanner.sv | 121 ++++++++++++
 tb/tb_bcd_display_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit BCD display scanner.
// Segment patterns are active-high, ordered gfedcba.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_ERR = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic DIG_ONES = 1'b0;
  localparam logic DIG_TENS = 1'b1;

  function automatic logic bcd_bad(
    input logic [7:0] v
  );
    return (v[3:0] > 4'd9) ||
           (v[7:4] > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Nibble to seven-segment decoder.
// Non-decimal nibbles show "E".
module bcd_seg_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // map one BCD nibble onto gfedcba
  always_comb begin
    seg = SEG_ERR;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed seven-segment driver with frame-aligned update.
// Optional BCD_SCAN_BLANK_EN blanks a leading zero on the tens digit.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_input,
  input  logic       bcd_valid,
  output logic       bcd_ready,
  input  logic       error_clear,
  output logic [6:0] seg_output,
  output logic [1:0] digit_enable,
  output logic       bcd_error
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic          digit_sel;
  logic [7:0]    pend_data;
  logic          pend_full;
  logic [7:0]    disp_data;

  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic          swap;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end &&
                     (digit_sel == DIG_TENS);
  assign bcd_ready = !pend_full;
  assign accept    = bcd_valid && bcd_ready;
  assign swap      = frame_end && pend_full;

  // slot timer and digit selector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit_sel <= DIG_ONES;
    end else if (slot_end) begin
      cnt       <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      cnt       <= cnt + 1'b1;
    end
  end

  // one-entry pending buffer; accept and swap are exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_data <= bcd_input;
      pend_full <= 1'b1;
    end else if (swap) begin
      pend_full <= 1'b0;
    end
  end

  // display register, only updated at frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= '0;
    end else if (swap) begin
      disp_data <= pend_data;
    end
  end

  // sticky error flag; a new set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_error <= 1'b0;
    end else if (swap && bcd_bad(pend_data)) begin
      bcd_error <= 1'b1;
    end else if (error_clear) begin
      bcd_error <= 1'b0;
    end
  end

  // pick the nibble for the active digit
  always_comb begin
    nib = disp_data[3:0];
    if (digit_sel == DIG_TENS) begin
      nib = disp_data[7:4];
    end
  end

  bcd_seg_decoder u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // segment output with optional leading-zero blanking
  always_comb begin
    seg_output = dec_seg;
`ifdef BCD_SCAN_BLANK_EN
    if ((digit_sel == DIG_TENS) &&
        (disp_data[7:4] == 4'd0)) begin
      seg_output = SEG_OFF;
    end
`endif
  end

  // one-hot digit strobe
  always_comb begin
    digit_enable = 2'b01;
    if (digit_sel == DIG_TENS) begin
      digit_enable = 2'b10;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner.
// Vector table, directed corner sequences, random run vs. model.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bcd_input;
  logic       bcd_valid;
  logic       bcd_ready;
  logic       error_clear;
  logic [6:0] seg_output;
  logic [1:0] digit_enable;
  logic       bcd_error;

  int checks = 0;
  int failures = 0;

`ifdef BCD_SCAN_BLANK_EN
  localparam logic [6:0] TENS0 = 7'h00;
`else
  localparam logic [6:0] TENS0 = 7'h3F;
`endif

  bcd_display_scanner #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bcd_input    (bcd_input),
    .bcd_valid    (bcd_valid),
    .bcd_ready    (bcd_ready),
    .error_clear  (error_clear),
    .seg_output   (seg_output),
    .digit_enable (digit_enable),
    .bcd_error    (bcd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] v;
    logic [6:0] ones;
    logic [6:0] tens;
    logic       err;
  } vec_t;

  vec_t tbl [9];

  logic [6:0] segtab [16];

  task automatic check(
    input string nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  // reset; returns at the negedge where t = 0
  task automatic do_reset();
    rst_n       = 1'b0;
    bcd_valid   = 1'b0;
    bcd_input   = 8'h00;
    error_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(
    input logic v,
    input logic [7:0] d
  );
    bcd_valid = v;
    bcd_input = d;
  endtask

  // model state
  int         m_t;
  logic       m_pf;
  logic [7:0] m_pd;
  logic [7:0] m_disp;
  logic       m_err;

  function automatic logic [10:0] model_out();
    logic       tens;
    logic [3:0] n;
    logic [6:0] s;
    tens = ((m_t / 4) % 2) == 1;
    n = tens ? m_disp[7:4] : m_disp[3:0];
    s = segtab[n];
`ifdef BCD_SCAN_BLANK_EN
    if (tens && m_disp[7:4] == 4'd0) s = 7'h00;
`endif
    return {s, (tens ? 2'b10 : 2'b01),
            !m_pf, m_err};
  endfunction

  task automatic model_step();
    logic fe;
    logic sw;
    logic bad;
    fe  = (m_t % 8) == 7;
    sw  = fe && m_pf;
    bad = (m_pd[3:0] > 9) || (m_pd[7:4] > 9);
    if (sw && bad) m_err = 1'b1;
    else if (error_clear) m_err = 1'b0;
    if (sw) m_disp = m_pd;
    if (bcd_valid && !m_pf) begin
      m_pd = bcd_input;
      m_pf = 1'b1;
    end else if (sw) begin
      m_pf = 1'b0;
    end
    m_t++;
  endtask

  initial begin
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
               7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h79, 7'h79,
               7'h79, 7'h79, 7'h79, 7'h79};
    tbl[0] = '{8'h27, 7'h07, 7'h5B, 1'b0};
    tbl[1] = '{8'h3C, 7'h79, 7'h4F, 1'b1};
    tbl[2] = '{8'h05, 7'h6D, TENS0, 1'b0};
    tbl[3] = '{8'h99, 7'h6F, 7'h6F, 1'b0};
    tbl[4] = '{8'hA0, 7'h3F, 7'h79, 1'b1};
    tbl[5] = '{8'h00, 7'h3F, TENS0, 1'b0};
    tbl[6] = '{8'h48, 7'h7F, 7'h66, 1'b0};
    tbl[7] = '{8'h61, 7'h06, 7'h7D, 1'b0};
    tbl[8] = '{8'h83, 7'h4F, 7'h7F, 1'b0};

    // reset state
    do_reset();
    check("rst_seg", 16'(seg_output), 16'h3F);
    check("rst_en", 16'(digit_enable), 16'h1);
    check("rst_rdy", 16'(bcd_ready), 16'h1);
    check("rst_err", 16'(bcd_error), 16'h0);
    repeat (4) @(negedge clk);
    check("rst_en_t4", 16'(digit_enable), 16'h2);

    // single loads from the table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      for (int t = 0; t < 16; t++) begin
        if (t == 2) drive(1'b1, tbl[i].v);
        else drive(1'b0, 8'h00);
        if (t == 3)
          check("vec_rdy_lo", 16'(bcd_ready), 16'h0);
        if (t == 7)
          check("vec_old", 16'(seg_output), 16'(TENS0));
        if (t == 8) begin
          check("vec_rdy_hi", 16'(bcd_ready), 16'h1);
          check("vec_err", 16'(bcd_error),
                16'(tbl[i].err));
        end
        if (t >= 8 && t < 12)
          check("vec_ones",
                {7'd0, digit_enable, seg_output},
                {7'd0, 2'b01, tbl[i].ones});
        if (t >= 12)
          check("vec_tens",
                {7'd0, digit_enable, seg_output},
                {7'd0, 2'b10, tbl[i].tens});
        @(negedge clk);
      end
    end

    // back-pressure: 0x15 then 0x31 held
    do_reset();
    drive(1'b1, 8'h15);
    @(negedge clk);
    drive(1'b1, 8'h31);
    for (int t = 1; t < 25; t++) begin
      if (t == 1 || t == 7)
        check("bp_rdy_lo", 16'(bcd_ready), 16'h0);
      if (t == 8)
        check("bp_rdy_hi", 16'(bcd_ready), 16'h1);
      if (t == 9) begin
        check("bp_acc", 16'(bcd_ready), 16'h0);
        drive(1'b0, 8'h00);
      end
      if (t == 8 || t == 11)
        check("bp_15o", 16'(seg_output), 16'h6D);
      if (t == 12 || t == 15)
        check("bp_15t", 16'(seg_output), 16'h06);
      if (t == 16 || t == 24)
        check("bp_31o", 16'(seg_output), 16'h06);
      if (t == 20)
        check("bp_31t", 16'(seg_output), 16'h4F);
      @(negedge clk);
    end

    // error flag: set, clear, set-beats-clear
    do_reset();
    drive(1'b1, 8'h3C);
    for (int t = 0; t < 17; t++) begin
      if (t == 1) drive(1'b0, 8'h00);
      error_clear = (t == 13 || t == 15);
      if (t == 14) drive(1'b1, 8'h3C);
      if (t == 15) drive(1'b0, 8'h00);
      if (t == 7)
        check("err_pre", 16'(bcd_error), 16'h0);
      if (t == 8) begin
        check("err_set", 16'(bcd_error), 16'h1);
        check("err_seg", 16'(seg_output), 16'h79);
      end
      if (t == 13)
        check("err_hold", 16'(bcd_error), 16'h1);
      if (t == 14)
        check("err_clr", 16'(bcd_error), 16'h0);
      if (t == 16)
        check("err_win", 16'(bcd_error), 16'h1);
      @(negedge clk);
    end
    error_clear = 1'b0;

    // mid-frame reset discards pending 0x99
    do_reset();
    drive(1'b1, 8'h99);
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    check("mr_pend", 16'(bcd_ready), 16'h0);
    rst_n = 1'b0;
    #1;
    check("mr_rdy", 16'(bcd_ready), 16'h1);
    check("mr_out",
          {7'd0, digit_enable, seg_output},
          {7'd0, 2'b01, 7'h3F});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t == 8)
        check("mr_ones", 16'(seg_output), 16'h3F);
      if (t == 12)
        check("mr_tens", 16'(seg_output),
              16'(TENS0));
      if (t == 15)
        check("mr_err", 16'(bcd_error), 16'h0);
      @(negedge clk);
    end

    // random run against the model
    do_reset();
    m_t = 0; m_pf = 0; m_pd = 0;
    m_disp = 0; m_err = 0;
    for (int c = 0; c < 800; c++) begin
      check("rnd",
            16'({seg_output, digit_enable,
                 bcd_ready, bcd_error}),
            16'(model_out()));
      if (!(bcd_valid && !bcd_ready)) begin
        bcd_valid = ($urandom_range(0, 2) == 0);
        bcd_input = 8'($urandom);
      end
      error_clear = ($urandom_range(0, 7) == 0);
      model_step();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
